// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with a one-deep holding register.
// A CPU write queues in[7:0]; a CPU read returns {busy, 14'b0, full}.
module io_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out,
    output logic        tx
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [7:0]      r_shift;
    logic [7:0]      r_hold;
    logic            r_full;
    logic [CW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic            r_tx;

    logic            w_baud_end;
    logic [2:0]      w_bit_nxt;
    logic            w_busy;
    logic            w_unused;

    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_bit_nxt  = r_bit + 3'd1;
    assign w_busy     = (r_state != S_IDLE);
    // Upper write byte carries no meaning for this slot.
    assign w_unused   = ^in[15:8];

    // Status word and serial line come straight from flops.
    assign out = {w_busy, 14'b0, r_full};
    assign tx  = r_tx;

    // Transmit FSM, holding register and baud/bit counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shift <= 8'h00;
            r_hold  <= 8'h00;
            r_full  <= 1'b0;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_tx    <= 1'b1;
        end else begin
            // A write while a frame is in flight lands in the holding register;
            // full is sampled before any drain, so a write against full=1 is lost.
            if (load && !r_full && (r_state != S_IDLE)) begin
                r_hold <= in[7:0];
                r_full <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    r_bit  <= 3'd0;
                    if (r_full) begin
                        r_shift <= r_hold;
                        r_full  <= 1'b0;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end else if (load) begin
                        r_shift <= in[7:0];
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end
                end

                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= 3'd0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end

                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit <= w_bit_nxt;
                            r_tx  <= r_shift[w_bit_nxt];
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end

                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        r_bit  <= 3'd0;
                        // Queued byte starts its frame with no idle gap.
                        if (r_full) begin
                            r_shift <= r_hold;
                            r_full  <= 1'b0;
                            r_state <= S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + CW'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx with CLKS_PER_BIT=4.
module tb_io_uart_tx;

    localparam int unsigned CPB = 4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] in;
    logic [15:0] out;
    logic        tx;

    int n_cmp;
    int n_fail;

    io_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .in    (in),
        .out   (out),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs set and outputs read 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for bit slot k of an 8N1 frame carrying d.
    function automatic logic fb(input logic [7:0] d, input int k);
        if (k == 0)      return 1'b0;
        else if (k <= 8) return d[k-1];
        else             return 1'b1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; in = 16'h0000;
        tick(); tick();
        rst_n = 1'b1;
        n_cmp++; if (out !== 16'h0000) begin n_fail++; $display("FAIL reset_out got=%h want=0000", out); end
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got=%b want=1", tx); end
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_idle_tx c=%0d got=%b want=1", c, tx); end
        end
    endtask

    task automatic test_single_byte();
        logic exp_tx;
        load = 1'b1; in = 16'hAB55;
        tick();
        load = 1'b0; in = 16'h0000;
        for (int c = 0; c < 40; c++) begin
            exp_tx = fb(8'h55, c / 4);
            n_cmp++; if (tx !== exp_tx) begin n_fail++; $display("FAIL single_tx c=%0d got=%b want=%b", c, tx, exp_tx); end
            n_cmp++; if (out !== 16'h8000) begin n_fail++; $display("FAIL single_out c=%0d got=%h want=8000", c, out); end
            tick();
        end
        n_cmp++; if (out !== 16'h0000) begin n_fail++; $display("FAIL single_done_out got=%h want=0000", out); end
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL single_done_tx got=%b want=1", tx); end
    endtask

    task automatic test_back_to_back();
        logic        exp_tx;
        logic [15:0] exp_out;
        load = 1'b1; in = 16'h000F;
        tick();
        for (int c = 0; c < 80; c++) begin
            load = (c == 4);
            in   = (c == 4) ? 16'h00F0 : 16'h0000;
            exp_tx  = (c < 40) ? fb(8'h0F, c / 4) : fb(8'hF0, (c - 40) / 4);
            exp_out = (c < 5) ? 16'h8000 : ((c < 40) ? 16'h8001 : 16'h8000);
            n_cmp++; if (tx !== exp_tx) begin n_fail++; $display("FAIL b2b_tx c=%0d got=%b want=%b", c, tx, exp_tx); end
            n_cmp++; if (out !== exp_out) begin n_fail++; $display("FAIL b2b_out c=%0d got=%h want=%h", c, out, exp_out); end
            tick();
        end
        load = 1'b0;
        n_cmp++; if (out !== 16'h0000) begin n_fail++; $display("FAIL b2b_done_out got=%h want=0000", out); end
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL b2b_done_tx got=%b want=1", tx); end
    endtask

    task automatic test_overflow();
        logic        exp_tx;
        logic [15:0] exp_out;
        load = 1'b1; in = 16'h0011;
        tick();
        for (int c = 0; c < 80; c++) begin
            load = (c < 2);
            in   = (c == 0) ? 16'h0022 : ((c == 1) ? 16'h0033 : 16'h0000);
            exp_tx  = (c < 40) ? fb(8'h11, c / 4) : fb(8'h22, (c - 40) / 4);
            exp_out = (c == 0) ? 16'h8000 : ((c < 40) ? 16'h8001 : 16'h8000);
            n_cmp++; if (tx !== exp_tx) begin n_fail++; $display("FAIL ovf_tx c=%0d got=%b want=%b", c, tx, exp_tx); end
            n_cmp++; if (out !== exp_out) begin n_fail++; $display("FAIL ovf_out c=%0d got=%h want=%h", c, out, exp_out); end
            tick();
        end
        load = 1'b0; in = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL ovf_idle_tx c=%0d got=%b want=1", c, tx); end
            n_cmp++; if (out !== 16'h0000) begin n_fail++; $display("FAIL ovf_idle_out c=%0d got=%h want=0000", c, out); end
            tick();
        end
    endtask

    task automatic test_boundary();
        logic        exp_tx;
        logic [15:0] exp_out;
        // Case A: load on the last stop cycle with nothing held.
        load = 1'b1; in = 16'h00A5;
        tick();
        for (int c = 0; c < 82; c++) begin
            load = (c == 39);
            in   = (c == 39) ? 16'h557E : 16'h0000;
            if (c < 40)       exp_tx = fb(8'hA5, c / 4);
            else if (c == 40) exp_tx = 1'b1;
            else              exp_tx = fb(8'h7E, (c - 41) / 4);
            if (c < 40)       exp_out = 16'h8000;
            else if (c == 40) exp_out = 16'h0001;
            else if (c < 81)  exp_out = 16'h8000;
            else              exp_out = 16'h0000;
            n_cmp++; if (tx !== exp_tx) begin n_fail++; $display("FAIL bnd_a_tx c=%0d got=%b want=%b", c, tx, exp_tx); end
            n_cmp++; if (out !== exp_out) begin n_fail++; $display("FAIL bnd_a_out c=%0d got=%h want=%h", c, out, exp_out); end
            tick();
        end
        // Case B: same late load while a byte is already held; it must be dropped.
        load = 1'b1; in = 16'h00A5;
        tick();
        for (int c = 0; c < 88; c++) begin
            load = (c == 0) || (c == 39);
            in   = (c == 0) ? 16'h003C : ((c == 39) ? 16'h007E : 16'h0000);
            if (c < 40)      exp_tx = fb(8'hA5, c / 4);
            else if (c < 80) exp_tx = fb(8'h3C, (c - 40) / 4);
            else             exp_tx = 1'b1;
            if (c == 0)      exp_out = 16'h8000;
            else if (c < 40) exp_out = 16'h8001;
            else if (c < 80) exp_out = 16'h8000;
            else             exp_out = 16'h0000;
            n_cmp++; if (tx !== exp_tx) begin n_fail++; $display("FAIL bnd_b_tx c=%0d got=%b want=%b", c, tx, exp_tx); end
            n_cmp++; if (out !== exp_out) begin n_fail++; $display("FAIL bnd_b_out c=%0d got=%h want=%h", c, out, exp_out); end
            tick();
        end
        load = 1'b0; in = 16'h0000;
    endtask

    task automatic test_reset_mid_frame();
        logic exp_tx;
        load = 1'b1; in = 16'h0096;
        tick();
        for (int c = 0; c < 18; c++) begin
            load = (c == 0);
            in   = (c == 0) ? 16'h005A : 16'h0000;
            exp_tx = fb(8'h96, c / 4);
            n_cmp++; if (tx !== exp_tx) begin n_fail++; $display("FAIL rmf_tx c=%0d got=%b want=%b", c, tx, exp_tx); end
            if (c == 17) rst_n = 1'b0;
            tick();
        end
        // Edge just taken was inside data bit 3 with the reset asserted.
        load = 1'b0; in = 16'h0000;
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rmf_after_tx got=%b want=1", tx); end
        n_cmp++; if (out !== 16'h0000) begin n_fail++; $display("FAIL rmf_after_out got=%h want=0000", out); end
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rmf_quiet_tx c=%0d got=%b want=1", c, tx); end
            n_cmp++; if (out !== 16'h0000) begin n_fail++; $display("FAIL rmf_quiet_out c=%0d got=%h want=0000", c, out); end
        end
        load = 1'b1; in = 16'h12C3;
        tick();
        load = 1'b0; in = 16'h0000;
        for (int c = 0; c < 40; c++) begin
            exp_tx = fb(8'hC3, c / 4);
            n_cmp++; if (tx !== exp_tx) begin n_fail++; $display("FAIL rmf_new_tx c=%0d got=%b want=%b", c, tx, exp_tx); end
            n_cmp++; if (out !== 16'h8000) begin n_fail++; $display("FAIL rmf_new_out c=%0d got=%h want=8000", c, out); end
            tick();
        end
        n_cmp++; if (out !== 16'h0000) begin n_fail++; $display("FAIL rmf_done_out got=%h want=0000", out); end
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rmf_done_tx got=%b want=1", tx); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        load   = 1'b0;
        in     = 16'h0000;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_boundary();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
